// File: rtl/scint_pulse_conditioner_if.sv
// Scintillator conditioner bus: raw lines, enable, count clear in;
// conditioned hits, hit OR and saturating hit count out.
interface scint_pulse_conditioner_if #(
  parameter int N_CH = 24
);
  logic [N_CH-1:0] pmt_in;
  logic            enable;
  logic            count_clr;
  logic [N_CH-1:0] hit_out;
  logic            hit_any;
  logic [15:0]     hit_count;

  modport master (
    output pmt_in, enable, count_clr,
    input  hit_out, hit_any, hit_count
  );

  modport slave (
    input  pmt_in, enable, count_clr,
    output hit_out, hit_any, hit_count
  );
endinterface

// File: rtl/scint_pulse_conditioner.sv
// Per-channel sync, glitch reject, stretch, dead time, hit counter.
// Ports: sys_clk_pll, rst_n (async low), bus (slave modport).
module scint_pulse_conditioner #(
  parameter int N_CH      = 24,
  parameter int MIN_WIDTH = 2,
  parameter int STRETCH   = 16,
  parameter int DEAD_TIME = 64
) (
  input  logic                       sys_clk_pll,
  input  logic                       rst_n,
  scint_pulse_conditioner_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    STRCH,
    DEAD
  } st_e;

  localparam logic [8:0] MW = 9'(MIN_WIDTH);
  localparam logic [8:0] ST = 9'(STRETCH);
  localparam logic [8:0] DT = 9'(DEAD_TIME);

  st_e             state_q [N_CH];
  st_e             state_d [N_CH];
  logic [7:0]      cnt_q   [N_CH];
  logic [7:0]      cnt_d   [N_CH];
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [N_CH-1:0] hit_q;
  logic [N_CH-1:0] hit_d;
  logic [N_CH-1:0] acc;
  logic [15:0]     count_q;
  logic [15:0]     count_d;
  logic [16:0]     sum;
  logic [8:0]      cnt_p1;

  always_comb begin
    cnt_p1 = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      acc[i]     = 1'b0;
      cnt_p1     = {1'b0, cnt_q[i]} + 9'd1;
      if (!bus.enable) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (sync2_q[i]) begin
              if (MIN_WIDTH == 1) begin
                state_d[i] = STRCH;
                cnt_d[i]   = '0;
                acc[i]     = 1'b1;
              end else begin
                state_d[i] = QUAL;
                cnt_d[i]   = 8'd1;
              end
            end
          end
          QUAL: begin
            if (!sync2_q[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_p1 == MW) begin
              state_d[i] = STRCH;
              cnt_d[i]   = '0;
              acc[i]     = 1'b1;
            end else begin
              cnt_d[i] = cnt_p1[7:0];
            end
          end
          STRCH: begin
            if (cnt_p1 == ST) begin
              state_d[i] = DEAD;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_p1[7:0];
            end
          end
          DEAD: begin
            // Expiry is counted so that the channel can leave DEAD
            // max(DEAD_TIME,1) edges after entering it; a still-high
            // line keeps it parked until a fresh rising edge.
            if (cnt_p1 < DT) begin
              cnt_d[i] = cnt_p1[7:0];
            end else if (!sync2_q[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      hit_d[i] = (state_d[i] == STRCH);
    end
  end

  // 17-bit sum so the carry flags saturation.
  always_comb begin
    sum = {1'b0, count_q};
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + 17'(acc[i]);
    end
    if (bus.count_clr) begin
      count_d = '0;
    end else if (sum[16]) begin
      count_d = 16'hFFFF;
    end else begin
      count_d = sum[15:0];
    end
  end

  always_ff @(posedge sys_clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hit_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= bus.pmt_in;
      sync2_q <= sync1_q;
      hit_q   <= hit_d;
      count_q <= count_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.hit_out   = hit_q;
  assign bus.hit_any   = |hit_q;
  assign bus.hit_count = count_q;

endmodule
